lcd_cmd_sequencer: RTL and testbench

Host-side command scheduler for the 8x8 LCD image controller. Buffers up to DEPTH 4-bit commands from a host and issues them to the controller one at a time over its cmd/cmd_valid/busy handshake. Detects the terminating Write command (code 0), waits for the controller's done, and reports status. Sits between the testbench or host stimulus and the LCD controller; the host never touches the controller handshake directly.

---
 rtl/lcd_seq_pkg.sv | 29 ++
 rtl/lcd_cmd_fifo.sv | 72 +++++++
 rtl/lcd_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared types and command codes for the LCD command sequencer.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_FLUSH,
    S_FINISH
  } state_t;

  // LCD controller command codes; Write (0) terminates a sequence.
  localparam logic [3:0] CMD_WRITE      = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP   = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RGHT = 4'd4;
  localparam logic [3:0] CMD_MAX_VAL    = 4'd5;
  localparam logic [3:0] CMD_MIN_VAL    = 4'd6;
  localparam logic [3:0] CMD_AVERAGE    = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW    = 4'd8;
  localparam logic [3:0] CMD_ROT_CW     = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X   = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y   = 4'd11;

  localparam logic [3:0] CMD_MAX_DEF    = CMD_MIRROR_Y;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// DEPTH x 4 synchronous FIFO; level tells full from empty, pointers wrap.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam int LW = AW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer, level and storage update; clr discards everything held.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the LCD controller.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter int         TIMEOUT = 63,
  parameter logic [3:0] CMD_MAX = CMD_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               issued_cnt,
  output logic                     seq_done,
  output logic                     err_badcmd,
  output logic                     err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  issued_q, issued_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        seq_done_q, seq_done_d;
  logic        bad_q, bad_d;
  logic        tmo_err_q, tmo_err_d;

  logic        f_push, f_pop, f_clr, f_full, f_empty;
  logic [3:0]  f_head;
  logic        offer;

  // Ready depends only on registered level and state, never on a same-cycle pop.
  assign host_ready = !f_full && (state_q != S_FINISH);
  assign offer      = host_valid && host_ready;
  assign f_push     = offer && (host_cmd <= CMD_MAX);

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (f_clr),
    .push  (f_push),
    .pop   (f_pop),
    .din   (host_cmd),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .level (fifo_level)
  );

  // Next-state, issue strobe, counters and sticky flags.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    issued_d    = issued_q;
    tmo_d       = tmo_q;
    seq_done_d  = seq_done_q;
    bad_d       = bad_q || (offer && (host_cmd > CMD_MAX));
    tmo_err_d   = tmo_err_q;
    f_pop       = 1'b0;
    f_clr       = 1'b0;
    case (state_q)
      S_IDLE:  if (!f_empty && !busy) state_d = S_ISSUE;
      S_ISSUE: begin
        cmd_d       = f_head;
        cmd_valid_d = 1'b1;
        f_pop       = 1'b1;
        if (issued_q != 8'hFF) issued_d = issued_q + 8'd1;
        state_d     = S_ARM;
      end
      // Controller may not have raised busy yet, so it is ignored here.
      S_ARM: begin
        tmo_d   = '0;
        state_d = (cmd_q == CMD_WRITE) ? S_FLUSH : S_WAIT;
      end
      S_WAIT: begin
        if (!busy) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      // Write-out length is up to the controller; wait for done without limit.
      S_FLUSH: if (done) begin
        seq_done_d = 1'b1;
        state_d    = S_FINISH;
      end
      S_FINISH: f_clr = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      issued_q    <= '0;
      tmo_q       <= '0;
      seq_done_q  <= 1'b0;
      bad_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      issued_q    <= issued_d;
      tmo_q       <= tmo_d;
      seq_done_q  <= seq_done_d;
      bad_q       <= bad_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign issued_cnt  = issued_q;
  assign seq_done    = seq_done_q;
  assign err_badcmd  = bad_q;
  assign err_timeout = tmo_err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: vector table plus scoreboard of issued commands.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic [3:0] fifo_level;
  logic [7:0] issued_cnt;
  logic       seq_done;
  logic       err_badcmd;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb [$];

  typedef struct {
    logic [3:0] cmd;
    bit         push;
    int         lvl;
    bit         bad;
    bit         rdy;
  } vec_t;
  vec_t tbl [11];

  lcd_cmd_sequencer #(.DEPTH(8), .TIMEOUT(63), .CMD_MAX(4'd11)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_cmd    (host_cmd),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .busy        (busy),
    .done        (done),
    .fifo_level  (fifo_level),
    .issued_cnt  (issued_cnt),
    .seq_done    (seq_done),
    .err_badcmd  (err_badcmd),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_host_ready"}, host_ready, 1);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_issued"}, issued_cnt, 0);
    chk({tag, "_seq_done"}, seq_done, 0);
    chk({tag, "_err_badcmd"}, err_badcmd, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    host_valid = 1'b0;
    done = 1'b0;
    sb.delete();
    cyc();
    check_reset(tag);
    reset = 1'b0;
  endtask

  task automatic wait_issued(input int n, input int budget);
    int k = 0;
    while (issued_cnt != 8'(n) && k < budget) begin
      cyc();
      k++;
    end
    chk("wait_issued", issued_cnt, n);
  endtask

  // Every issue strobe must match the oldest command still expected.
  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue got cmd=%0d expected no issue", cmd);
        end else begin
          e = sb.pop_front();
          chk("issue_order", cmd, e);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Fill phase with busy held high: level, bad flag and ready after each offer.
    tbl[0]  = '{4'd3,  1'b1, 1, 1'b0, 1'b1};
    tbl[1]  = '{4'd4,  1'b1, 2, 1'b0, 1'b1};
    tbl[2]  = '{4'd13, 1'b0, 2, 1'b1, 1'b1};
    tbl[3]  = '{4'd5,  1'b1, 3, 1'b1, 1'b1};
    tbl[4]  = '{4'd6,  1'b1, 4, 1'b1, 1'b1};
    tbl[5]  = '{4'd7,  1'b1, 5, 1'b1, 1'b1};
    tbl[6]  = '{4'd8,  1'b1, 6, 1'b1, 1'b1};
    tbl[7]  = '{4'd9,  1'b1, 7, 1'b1, 1'b1};
    tbl[8]  = '{4'd10, 1'b1, 8, 1'b1, 1'b0};
    tbl[9]  = '{4'd2,  1'b0, 8, 1'b1, 1'b0};
    tbl[10] = '{4'd15, 1'b0, 8, 1'b1, 1'b0};

    reset = 1'b1; host_valid = 1'b0; host_cmd = '0; busy = 1'b0; done = 1'b0;
    fork monitor(); join_none
    cyc();

    // Shift-up then Write: latency, ordering, done handling.
    do_reset("rst0");
    host_valid = 1'b1; host_cmd = 4'd1; sb.push_back(4'd1);
    cyc();
    chk("lat_e0", cmd_valid, 0);
    host_cmd = 4'd0; sb.push_back(4'd0);
    cyc();
    chk("lat_e1", cmd_valid, 0);
    host_valid = 1'b0;
    cyc();
    chk("lat_e2_valid", cmd_valid, 1);
    chk("lat_e2_cmd", cmd, 1);
    cyc();
    chk("lat_e3_valid", cmd_valid, 0);
    wait_issued(2, 50);
    cyc(); cyc(); cyc();
    chk("flush_no_done", seq_done, 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("seq_done", seq_done, 1);
    chk("finish_ready", host_ready, 0);
    chk("finish_issued", issued_cnt, 2);
    chk("sb_empty_t1", sb.size(), 0);
    host_valid = 1'b1; host_cmd = 4'd3;
    cyc();
    host_valid = 1'b0;
    chk("finish_no_push", fifo_level, 0);

    // Image load: fill to full with busy high, bad code refused, then drain.
    do_reset("rst1");
    busy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      host_valid = 1'b1;
      host_cmd = tbl[i].cmd;
      if (tbl[i].push) sb.push_back(tbl[i].cmd);
      cyc();
      chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("vec%0d_bad", i), err_badcmd, tbl[i].bad);
      chk($sformatf("vec%0d_ready", i), host_ready, tbl[i].rdy);
    end
    host_valid = 1'b0;
    repeat (50) cyc();
    chk("load_no_issue", issued_cnt, 0);
    busy = 1'b0;
    wait_issued(8, 200);
    repeat (4) cyc();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_level", fifo_level, 0);
    chk("drain_ready", host_ready, 1);
    chk("bad_sticky", err_badcmd, 1);

    // Busy stuck high after issuing 5: timeout after 63 cycles in wait.
    do_reset("rst2");
    host_valid = 1'b1; host_cmd = 4'd5; sb.push_back(4'd5);
    cyc();
    host_valid = 1'b0;
    cyc();
    busy = 1'b1;
    cyc();
    cyc();
    host_valid = 1'b1; host_cmd = 4'd3;
    cyc();
    host_valid = 1'b0;
    chk("tmo_pending_level", fifo_level, 1);
    repeat (61) cyc();
    chk("tmo_before", err_timeout, 0);
    cyc();
    chk("tmo_after", err_timeout, 1);
    chk("tmo_ready", host_ready, 0);
    busy = 1'b0;
    repeat (20) cyc();
    chk("tmo_issued", issued_cnt, 1);
    chk("tmo_discard", fifo_level, 0);
    chk("tmo_sticky", err_timeout, 1);

    // Push and pop in the same cycle at level 3.
    do_reset("rst3");
    busy = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      host_valid = 1'b1; host_cmd = 4'(i); sb.push_back(4'(i));
      cyc();
    end
    host_valid = 1'b0;
    chk("pp_level_pre", fifo_level, 3);
    busy = 1'b0;
    cyc();
    chk("pp_level_issue", fifo_level, 3);
    host_valid = 1'b1; host_cmd = 4'd6; sb.push_back(4'd6);
    busy = 1'b1;
    cyc();
    host_valid = 1'b0;
    chk("pp_level_post", fifo_level, 3);
    repeat (5) cyc();
    busy = 1'b0;
    wait_issued(4, 100);
    repeat (4) cyc();
    chk("pp_sb_empty", sb.size(), 0);

    // Reset while waiting in flush.
    do_reset("rst4");
    host_valid = 1'b1; host_cmd = 4'd0; sb.push_back(4'd0);
    cyc();
    host_valid = 1'b0;
    wait_issued(1, 20);
    cyc(); cyc();
    chk("flush_ready", host_ready, 1);
    reset = 1'b1;
    cyc();
    check_reset("rst_flush");
    reset = 1'b0;
    cyc();
    chk("post_flush_cmd_valid", cmd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
